// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers DrawX/DrawY from active-low HS/VS,
// checks line/frame timing against the nominal frame and reports lock/errors.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned LOS_PIXELS  = 1600
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       pix_ce,
  input  logic       hs,
  input  logic       vs,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam int unsigned CW = 10;
  localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned LW = $clog2(LOS_PIXELS + 1);

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_X      = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] VS_Y      = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);
  localparam logic [LW-1:0] LOS_LIMIT = LW'(LOS_PIXELS);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [LW-1:0] los_q, los_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          active_q, active_d;
  logic          fs_q, fs_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;

  logic          hs_fall, vs_fall;
  logic [CW-1:0] hpred, vpred;
  logic          checking, line_err, frame_err, los_fire;
  logic [GW-1:0] good_inc;
  logic [LW-1:0] los_inc;

  // State and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_SEARCH;
      good_q   <= '0;
      los_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      los_q    <= los_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  // Coordinate prediction, timing checks and lock state machine
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    los_d    = los_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    fs_d     = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;

    hs_fall = hs_q & ~hs;
    vs_fall = vs_q & ~vs;

    hpred = (x_q == H_LAST) ? '0 : x_q + CW'(1);
    vpred = y_q;
    if (hpred == '0) begin
      vpred = (y_q == V_LAST) ? '0 : y_q + CW'(1);
    end

    checking  = (state_q != S_SEARCH);
    line_err  = checking & hs_fall & (hpred != HS_X);
    frame_err = checking & vs_fall & (vpred != VS_Y);
    los_inc   = los_q + LW'(1);
    los_fire  = ~hs_fall & (los_inc == LOS_LIMIT);
    good_inc  = good_q + GW'(1);

    if (pix_ce) begin
      hs_d  = hs;
      vs_d  = vs;
      x_d   = hs_fall ? HS_X : hpred;
      y_d   = vs_fall ? VS_Y : vpred;
      los_d = (hs_fall | los_fire) ? '0 : los_inc;

      case (state_q)
        S_SEARCH: begin
          if (vs_fall) begin
            state_d = S_TRACK;
            good_d  = '0;
          end
        end
        S_TRACK: begin
          if (line_err | frame_err) begin
            good_d = '0;
          end else if (vs_fall) begin
            good_d = good_inc;
            if (good_inc == GOOD_LOCK) begin
              state_d = S_LOCKED;
            end
          end
        end
        S_LOCKED: begin
          if (line_err | frame_err) begin
            state_d = S_SEARCH;
          end
        end
        default: state_d = S_SEARCH;
      endcase

      // Loss of signal overrides everything else
      if (los_fire) begin
        state_d = S_SEARCH;
        good_d  = '0;
      end

      locked_d = (state_d == S_LOCKED);
      active_d = locked_d & (x_d < H_ACT) & (y_d < V_ACT);
      fs_d     = locked_d & (x_d == '0) & (y_d == '0);
      err_d    = line_err | frame_err | los_fire;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign active      = active_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign sync_err    = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down frame so every
// scenario (acquire, track, short line, LOS, stall, mid-frame reset) stays short.
module tb_vga_sync_decoder;

  localparam int H_ACTIVE    = 16;
  localparam int H_FP        = 4;
  localparam int H_SYNC      = 4;
  localparam int H_TOTAL     = 28;
  localparam int V_ACTIVE    = 6;
  localparam int V_FP        = 2;
  localparam int V_SYNC      = 2;
  localparam int V_TOTAL     = 12;
  localparam int LOCK_FRAMES = 2;
  localparam int LOS_PIXELS  = 56;
  localparam int HS_X        = H_ACTIVE + H_FP;
  localparam int VS_Y        = V_ACTIVE + V_FP;
  localparam int FRAME       = H_TOTAL * V_TOTAL;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic [9:0] DrawX, DrawY;
  logic       active, frame_start, locked, sync_err;

  vga_sync_decoder #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_TOTAL(V_TOTAL),
    .LOCK_FRAMES(LOCK_FRAMES), .LOS_PIXELS(LOS_PIXELS)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_ce(pix_ce), .hs(hs), .vs(vs),
    .DrawX(DrawX), .DrawY(DrawY), .active(active), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Generator model state
  int gx = 0, gy = 0, line_len = H_TOTAL;
  bit hs_hold = 1'b0;
  bit hs_prev = 1'b1, vs_prev = 1'b1;
  int pix_idx = 0, cur_idx = 0, last_hsf_idx = 0;
  int cur_x, cur_y;
  bit cur_hsf, cur_vsf;
  logic [9:0] obs_x, obs_y;
  logic obs_act, obs_fs, obs_lock, obs_err;
  logic idle_pulse;

  // One pixel: drive generator sample with pix_ce, capture outputs, idle Clk
  task automatic pixel();
    bit h, v;
    cur_x = gx; cur_y = gy; cur_idx = pix_idx;
    h = hs_hold || !(gx >= HS_X && gx < HS_X + H_SYNC);
    v = !(gy >= VS_Y && gy < VS_Y + V_SYNC);
    cur_hsf = hs_prev && !h;
    cur_vsf = vs_prev && !v;
    if (cur_hsf) last_hsf_idx = pix_idx;
    hs_prev = h; vs_prev = v;
    hs = h; vs = v; pix_ce = 1'b1;
    @(posedge Clk); #1;
    obs_x = DrawX; obs_y = DrawY; obs_act = active;
    obs_fs = frame_start; obs_lock = locked; obs_err = sync_err;
    pix_ce = 1'b0;
    @(posedge Clk); #1;
    idle_pulse = frame_start | sync_err;
    pix_idx++;
    gx++;
    if (gx >= line_len) begin
      gx = 0;
      line_len = H_TOTAL;
      gy = (gy == V_TOTAL - 1) ? 0 : gy + 1;
    end
  endtask

  task automatic go_to(input int x, input int y);
    for (int i = 0; i < FRAME && !(gx == x && gy == y); i++) pixel();
  endtask

  task automatic run_to_vsf(input int n, input int budget, output bit early,
                            output bit at_n, output int errs, output bit tmo);
    int seen = 0;
    early = 1'b0; at_n = 1'b0; errs = 0; tmo = 1'b1;
    for (int i = 0; i < budget; i++) begin
      pixel();
      if (obs_err === 1'b1) errs++;
      if (cur_vsf) seen++;
      if (cur_vsf && seen == n) begin
        at_n = (obs_lock === 1'b1);
        tmo = 1'b0;
        break;
      end
      if (obs_lock === 1'b1) early = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; pix_ce = 1'b0; hs = 1'b1; vs = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({DrawX, DrawY} !== 20'd0) begin
      errors++; $display("FAIL reset_coords got x=%0d y=%0d want 0 0", DrawX, DrawY);
    end
    checks++;
    if ({active, frame_start, locked, sync_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {active, frame_start, locked, sync_err});
    end
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_acquire();
    bit early, at_n, tmo; int errs;
    run_to_vsf(3, 4 * FRAME, early, at_n, errs, tmo);
    checks++; if (tmo)   begin errors++; $display("FAIL acq_timeout got timeout want 3 vs falls"); end
    checks++; if (early) begin errors++; $display("FAIL acq_early got locked=1 want 0 before 3rd vs fall"); end
    checks++; if (!at_n) begin errors++; $display("FAIL acq_lock got locked=0 want 1 at 3rd vs fall"); end
    checks++; if (errs != 0) begin errors++; $display("FAIL acq_errs got %0d want 0", errs); end
  endtask

  task automatic test_track();
    int coord_bad = 0, act_bad = 0, act_cnt = 0, fs_cnt = 0, fs_bad = 0;
    int fs_first = -1, fs_gap = 0, err_cnt = 0, unlock = 0, idle = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      pixel();
      if (obs_x !== 10'(cur_x) || obs_y !== 10'(cur_y)) coord_bad++;
      if (obs_act !== ((cur_x < H_ACTIVE) && (cur_y < V_ACTIVE))) act_bad++;
      if (obs_act === 1'b1) act_cnt++;
      if (obs_fs === 1'b1) begin
        fs_cnt++;
        if (cur_x != 0 || cur_y != 0) fs_bad++;
        if (fs_first < 0) fs_first = cur_idx; else fs_gap = cur_idx - fs_first;
      end
      if (obs_err === 1'b1) err_cnt++;
      if (obs_lock !== 1'b1) unlock++;
      if (idle_pulse !== 1'b0) idle++;
    end
    checks++; if (coord_bad != 0) begin errors++; $display("FAIL trk_coords got %0d bad want 0", coord_bad); end
    checks++; if (act_bad != 0) begin errors++; $display("FAIL trk_active got %0d bad want 0", act_bad); end
    checks++; if (act_cnt != 2 * H_ACTIVE * V_ACTIVE) begin errors++; $display("FAIL trk_act_cnt got %0d want %0d", act_cnt, 2 * H_ACTIVE * V_ACTIVE); end
    checks++; if (fs_cnt != 2) begin errors++; $display("FAIL trk_fs_cnt got %0d want 2", fs_cnt); end
    checks++; if (fs_bad != 0) begin errors++; $display("FAIL trk_fs_pos got %0d bad want 0", fs_bad); end
    checks++; if (fs_gap != FRAME) begin errors++; $display("FAIL trk_fs_gap got %0d want %0d", fs_gap, FRAME); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL trk_err got %0d want 0", err_cnt); end
    checks++; if (unlock != 0) begin errors++; $display("FAIL trk_lock got %0d unlocked want 0", unlock); end
    checks++; if (idle != 0) begin errors++; $display("FAIL trk_idle_pulse got %0d want 0", idle); end
  endtask

  task automatic test_short_line();
    int err_cnt = 0, ex = -1, ey = -1;
    bit seen = 1'b0, lock_at = 1'b1, lock_before = 1'b0, lock_prev = 1'b1;
    bit early, at_n, tmo; int errs;
    go_to(0, 2);
    line_len = H_TOTAL - 1;
    for (int i = 0; i < 2 * H_TOTAL; i++) begin
      pixel();
      if (obs_err === 1'b1) begin
        err_cnt++;
        if (!seen) begin
          seen = 1'b1; ex = cur_x; ey = cur_y;
          lock_at = (obs_lock === 1'b1); lock_before = lock_prev;
        end
      end
      lock_prev = (obs_lock === 1'b1);
    end
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL short_err_cnt got %0d want 1", err_cnt); end
    checks++; if (ex != HS_X || ey != 3) begin errors++; $display("FAIL short_err_pos got %0d,%0d want %0d,3", ex, ey, HS_X); end
    checks++; if (lock_at) begin errors++; $display("FAIL short_lock_drop got locked=1 want 0 at error"); end
    checks++; if (!lock_before) begin errors++; $display("FAIL short_lock_before got locked=0 want 1"); end
    run_to_vsf(3, 4 * FRAME, early, at_n, errs, tmo);
    checks++; if (tmo || early || !at_n) begin errors++; $display("FAIL short_relock got tmo=%0d early=%0d lock=%0d want 0 0 1", tmo, early, at_n); end
    checks++; if (errs != 0) begin errors++; $display("FAIL short_relock_errs got %0d want 0", errs); end
  endtask

  task automatic test_los();
    int fire_idx = -1, exp_idx, err_cnt = 0;
    bit lock_at = 1'b1, lock_before = 1'b0, lock_prev = 1'b1;
    bit early, at_n, tmo; int errs;
    go_to(0, 1);
    hs_hold = 1'b1;
    exp_idx = last_hsf_idx + LOS_PIXELS;
    for (int i = 0; i < 2 * LOS_PIXELS; i++) begin
      pixel();
      if (obs_err === 1'b1) begin
        err_cnt++;
        if (fire_idx < 0) begin
          fire_idx = cur_idx; lock_at = (obs_lock === 1'b1); lock_before = lock_prev;
        end
      end
      lock_prev = (obs_lock === 1'b1);
      if (fire_idx >= 0 && gx == 0) break;
    end
    hs_hold = 1'b0;
    checks++; if (fire_idx != exp_idx) begin errors++; $display("FAIL los_time got idx %0d want %0d", fire_idx, exp_idx); end
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL los_err_cnt got %0d want 1", err_cnt); end
    checks++; if (lock_at || !lock_before) begin errors++; $display("FAIL los_lock got at=%0d before=%0d want 0 1", lock_at, lock_before); end
    run_to_vsf(3, 4 * FRAME, early, at_n, errs, tmo);
    checks++; if (tmo || early || !at_n) begin errors++; $display("FAIL los_relock got tmo=%0d early=%0d lock=%0d want 0 0 1", tmo, early, at_n); end
    checks++; if (errs != 0) begin errors++; $display("FAIL los_relock_errs got %0d want 0", errs); end
  endtask

  task automatic test_stall();
    int stall_bad = 0, coord_bad = 0, err_cnt = 0, unlock = 0;
    go_to(10, 3);
    for (int i = 0; i < 1000; i++) begin
      @(posedge Clk); #1;
      if (DrawX !== obs_x || DrawY !== obs_y || locked !== 1'b1 || active !== obs_act ||
          sync_err !== 1'b0 || frame_start !== 1'b0) stall_bad++;
    end
    for (int i = 0; i < FRAME; i++) begin
      pixel();
      if (obs_x !== 10'(cur_x) || obs_y !== 10'(cur_y)) coord_bad++;
      if (obs_err === 1'b1) err_cnt++;
      if (obs_lock !== 1'b1) unlock++;
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad Clk want 0", stall_bad); end
    checks++; if (coord_bad != 0) begin errors++; $display("FAIL stall_resume got %0d bad want 0", coord_bad); end
    checks++; if (err_cnt != 0 || unlock != 0) begin errors++; $display("FAIL stall_state got err=%0d unlock=%0d want 0 0", err_cnt, unlock); end
  endtask

  task automatic test_reset_mid();
    bit early, at_n, tmo; int errs;
    go_to(10, 3);
    checks++; if (obs_act !== 1'b1) begin errors++; $display("FAIL rst_pre_active got %b want 1", obs_act); end
    Reset_n = 1'b0;
    #2;
    checks++;
    if ({DrawX, DrawY} !== 20'd0) begin
      errors++; $display("FAIL rst_mid_coords got x=%0d y=%0d want 0 0", DrawX, DrawY);
    end
    checks++;
    if ({active, frame_start, locked, sync_err} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_flags got %b want 0000", {active, frame_start, locked, sync_err});
    end
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    run_to_vsf(3, 4 * FRAME, early, at_n, errs, tmo);
    checks++; if (tmo || early) begin errors++; $display("FAIL rst_relock_early got tmo=%0d early=%0d want 0 0", tmo, early); end
    checks++; if (!at_n) begin errors++; $display("FAIL rst_relock got locked=0 want 1 at 3rd vs fall"); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_track();
    test_short_line();
    test_los();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator. Takes active-low HS/VS, recovers the pixel coordinates, and checks the timing against the nominal 640x480 frame.
- Outputs: DrawX, DrawY, an active-video flag, a frame-start strobe, a lock indication and error pulses.
- Sits on the 50 MHz domain next to the timing generator, fed by its hs/vs and a pixel strobe.
- Used for frame capture, on-board self-check of the timing generator, and the scoreboard in the video benches.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels after active, before HS low)
H_SYNC, 96, HS low width
H_TOTAL, 800, pixels per line
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_TOTAL, 525, lines per frame
LOCK_FRAMES, 2, consecutive clean frames required to assert locked
LOS_PIXELS, 1600, pixel strobes without an HS fall before loss-of-signal

Ports:
Clk  in  1  50 MHz system clock
Reset_n  in  1  asynchronous active-low reset
pix_ce  in  1  pixel strobe (one Clk per pixel, 25 MHz rate); all state advances only when high
hs  in  1  horizontal sync, active low
vs  in  1  vertical sync, active low
DrawX  out  10  recovered column of the last sampled pixel
DrawY  out  10  recovered row of the last sampled pixel
active  out  1  high when DrawX<H_ACTIVE, DrawY<V_ACTIVE and locked
frame_start  out  1  one-Clk pulse when (DrawX,DrawY) becomes (0,0) while locked
locked  out  1  timing verified stable
sync_err  out  1  one-Clk pulse on any timing mismatch or loss of signal

Behaviour:
- Reset (async, Reset_n=0):
  - DrawX=0, DrawY=0, active=0, frame_start=0, locked=0, sync_err=0.
  - hs_d=1, vs_d=1, so no false edge is detected out of reset.
  - State SEARCH, good-frame count 0, LOS counter 0.
  - Deassertion is taken synchronously on the next Clk edge.
- pix_ce=0: every register holds, and the pulse outputs are 0.
- On each Clk with pix_ce=1:
  - hs_fall = hs_d & ~hs; vs_fall = vs_d & ~vs; then hs_d<=hs, vs_d<=vs.
  - Next-X predicted: hpred = (DrawX==H_TOTAL-1) ? 0 : DrawX+1.
  - Next-Y predicted: vpred = DrawY+1, wrapping V_TOTAL-1 to 0, applied only when hpred==0; otherwise DrawY.
  - DrawX <= hs_fall ? H_ACTIVE+H_FP : hpred.
  - DrawY <= vs_fall ? V_ACTIVE+V_FP : vpred.
  - vs_fall has priority over the line wrap when both fall on the same pixel (the generator drops VS on the pixel where X wraps to 0).
- Latency: outputs reflect the pixel sampled on the previous pix_ce, one Clk later. Coordinates are registered, not combinational.
- Checks (only in TRACK and LOCKED):
  - Line error: hs_fall with hpred != H_ACTIVE+H_FP.
  - Frame error: vs_fall with vpred != V_ACTIVE+V_FP.
  - Either one pulses sync_err for one Clk.
- Loss of signal:
  - LOS counter increments per pix_ce and clears on hs_fall.
  - When it reaches LOS_PIXELS: sync_err pulse, state goes to SEARCH, counter clears.
- State machine:
  - SEARCH: locked=0. First vs_fall goes to TRACK with good count 0.
  - TRACK: locked=0.
    - Error: good count <= 0, stay in TRACK.
    - Each error-free vs_fall after the first: good count +1.
    - Good count reaching LOCK_FRAMES: go to LOCKED and assert locked on that same Clk.
  - LOCKED: locked=1. Any line/frame error or LOS: go to SEARCH and drop locked on the same Clk as the sync_err pulse.
- Counters free-run in every state. active and frame_start are forced 0 unless locked.
- Coordinates stay in 0..H_TOTAL-1 / 0..V_TOTAL-1, the wrap is explicit, and there is no 10-bit overflow.
- Reset mid-frame: everything returns to reset values. Relock needs a vs_fall plus LOCK_FRAMES clean frames.

Test Plan:
- Generator-driven nominal stream (hs low at X 656..751, vs low at Y 490..491), from reset:
  - locked rises at the 3rd vs_fall.
  - After that, DrawX/DrawY equal the generator counters, one Clk late, on every pixel.
  - active high for exactly 307200 pixels per frame.
- After lock, frame_start pulses once per 420000 pix_ce (800x525), coincident with DrawX=0, DrawY=0.
- One line shortened to 799 pixels while locked:
  - sync_err pulses once and locked drops on the next hs_fall.
  - Relock after 2 further clean frames (3rd vs_fall).
- HS held high after lock:
  - sync_err pulses and locked=0 exactly 1600 pix_ce after the last hs_fall.
  - Restoring the sync relocks.
- pix_ce held low for 1000 Clk mid-line: DrawX/DrawY/state frozen, no LOS, no error; the stream resumes seamlessly.
- Reset_n pulsed low mid-frame:
  - All outputs 0 immediately, asynchronously.
  - After release, locked stays 0 until the 3rd subsequent vs_fall.
